// File: rtl/subtrator_pkg.sv
// Shared definitions for the bit-serial subtractor: FSM encoding and default width.
package subtrator_pkg;

    localparam int SUB_N_DEF = 4;

    typedef enum logic [1:0] {
        OCIOSO = 2'b00,
        CALC   = 2'b01,
        FIM    = 2'b10
    } state_t;

endpackage

// File: rtl/somadorCompleto.sv
// One-bit full adder slice; purely combinational.
module somadorCompleto (
    output logic s,
    output logic cout,
    input  logic a,
    input  logic b,
    input  logic cin
);

    assign s    = a ^ b ^ cin;
    assign cout = (a & b) | (a & cin) | (b & cin);

endmodule

// File: rtl/subtrator_serial.sv
// Bit-serial N-bit subtractor ss = aa - bb - bbin, LSB first through one full-adder slice.
// Latency N+1 cycles start-to-done; start is ignored while busy, results held until the next done.
module subtrator_serial
    import subtrator_pkg::*;
#(
    parameter int N = SUB_N_DEF
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic [N-1:0] aa,
    input  logic [N-1:0] bb,
    input  logic         bbin,
    output logic         busy,
    output logic         done,
    output logic [N-1:0] ss,
    output logic         bbout,
    output logic         ovf
);

    localparam int CW = $clog2(N);
    localparam logic [CW-1:0] LAST = CW'(N - 1);

    state_t         r_state;
    logic [CW-1:0]  r_cnt;
    logic [N-1:0]   r_a;
    logic [N-1:0]   r_b;
    logic [N-1:0]   r_res;
    logic           r_carry;

    logic           w_s;
    logic           w_cout;
    logic           w_b_inv;

    // Subtraction as a + ~b + ~borrow: the slice only ever sees the inverted subtrahend bit.
    assign w_b_inv = ~r_b[0];

    somadorCompleto u_slice (
        .s    (w_s),
        .cout (w_cout),
        .a    (r_a[0]),
        .b    (w_b_inv),
        .cin  (r_carry)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= OCIOSO;
            r_cnt   <= '0;
            r_a     <= '0;
            r_b     <= '0;
            r_res   <= '0;
            r_carry <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b0;
            ss      <= '0;
            bbout   <= 1'b0;
            ovf     <= 1'b0;
        end else begin
            done <= 1'b0;
            case (r_state)
                OCIOSO, FIM: begin
                    if (start) begin
                        r_a     <= aa;
                        r_b     <= bb;
                        r_carry <= ~bbin;
                        r_cnt   <= '0;
                        busy    <= 1'b1;
                        r_state <= CALC;
                    end else begin
                        r_state <= OCIOSO;
                    end
                end
                CALC: begin
                    r_res   <= {w_s, r_res[N-1:1]};
                    r_a     <= r_a >> 1;
                    r_b     <= r_b >> 1;
                    r_carry <= w_cout;
                    r_cnt   <= r_cnt + 1'b1;
                    if (r_cnt == LAST) begin
                        // r_carry is the carry into the MSB on this final slice step.
                        ss      <= {w_s, r_res[N-1:1]};
                        bbout   <= ~w_cout;
                        ovf     <= r_carry ^ w_cout;
                        done    <= 1'b1;
                        busy    <= 1'b0;
                        r_cnt   <= '0;
                        r_state <= FIM;
                    end
                end
                default: begin
                    busy    <= 1'b0;
                    r_state <= OCIOSO;
                end
            endcase
        end
    end

endmodule
